store_align_queue: RTL
======================

// Module: store_align_queue
// PURPOSE
//  Parametrised store-data path between the MEM stage and the data-memory port.
//  - Queues up to DEPTH pending stores.
//  - Aligns each store's data and byte-enables to its address offset and access size.
//  - Splits a store that crosses a word boundary into two memory writes.
//  - Presents one write at a time on the mem_write/mem_resp port.
// PARAMETERS
//  DATA_W   32  memory data width in bits; multiple of 8, power of two
//  ADDR_W   32  address width in bits
//  DEPTH    4   queue entries; power of two, >= 2
// PORTS
//  clk              in   1              clock
//  rst              in   1              synchronous, active-high reset
//  st_valid         in   1              store request valid
//  st_ready         out  1              queue can accept a store (= !full)
//  st_addr          in   ADDR_W         byte address of the store
//  st_data          in   DATA_W         store data, right-justified (LSB = byte 0)
//  st_size          in   2              log2(bytes): 0=B, 1=H, 2=W, 3=D
//  mem_write        out  1              write request, held until mem_resp
//  mem_address      out  ADDR_W         word-aligned write address
//  mem_wdata        out  DATA_W         lane-aligned write data
//  mem_byte_enable  out  DATA_W/8       byte-lane enables
//  mem_resp         in   1              write accepted/completed, 1-cycle pulse
//  count            out  $clog2(DEPTH)+1  number of occupied entries
//  busy             out  1              count != 0 or FSM not in IDLE
// BEHAVIOUR
//  Reset values
//  - All outputs reset to 0, except st_ready, which resets to 1.
//  - FIFO pointers cleared; FSM goes to IDLE.
//  - Reset takes effect at the next edge, including mid-transfer: an in-flight beat is abandoned and no HI beat is issued.
//  Definitions (BYTES = DATA_W/8, OB = $clog2(BYTES))
//  - Push: st_valid & st_ready.
//  - Entry stores {addr, data, size}.
//  - If st_size > OB, the size is clamped to OB on push.
//  - st_ready depends only on full; there is no same-cycle bypass.
//  Alignment of the head entry (nb = 1<<size, off = addr[OB-1:0])
//  - base = addr with its low OB bits cleared.
//  - m = ((1<<nb)-1) << off, computed in 2*BYTES bits; d = data << 8*off, computed in 2*DATA_W bits.
//  - LO beat: address = base, byte_enable = m[BYTES-1:0], wdata = d[DATA_W-1:0].
//  - HI beat (only when off+nb > BYTES): address = base + BYTES, byte_enable = m[2*BYTES-1:BYTES], wdata = d[2*DATA_W-1:DATA_W].
//  - Bytes of wdata whose enables are 0 are driven 0.
//  FSM states: IDLE, WR_LO, WR_HI (registered state; outputs registered off state + head entry)
//  - IDLE: if count != 0, go to WR_LO at the next edge. Latency: a push at edge N gives mem_write=1 in cycle N+1.
//  - WR_LO: mem_write=1 with LO fields.
//    - On mem_resp with a split pending: go to WR_HI.
//    - On mem_resp with no split: pop. If count>1 stay in WR_LO with the next head (back-to-back, no bubble); otherwise go to IDLE.
//  - WR_HI: mem_write=1 with HI fields. On mem_resp: pop, then take the same next-state choice as WR_LO.
//  - mem_resp seen in IDLE is ignored.
//  - Address, data and byte-enable outputs are stable while mem_write=1, and are 0 in IDLE.
//  Boundary rules
//  - Push and pop in the same cycle: count unchanged; entry order is preserved.
//  - Full: st_ready=0; st_valid is ignored, with no overwrite.
//  - Pointers wrap modulo DEPTH; count distinguishes full from empty.
//  - A pop only ever occurs after the final beat of the head store.
// STRUCTURE
//  Package store_align_pkg
//  - size_t enum (SZ_B/SZ_H/SZ_W/SZ_D).
//  - sq_state_t enum (IDLE/WR_LO/WR_HI).
//  - sq_entry_t struct {addr, data, size}.
//  Sub-module store_lane_align
//  - Purely combinational {addr, data, size} -> {lo/hi addr, wdata, byte_enable, split}.
//  - Reused later by the load-side extractor.
//  Top: FIFO storage array, pointers/count, FSM and output registers.
// TESTING (DATA_W=32, DEPTH=4; mem_resp one cycle after mem_write unless stated)
//  1. SB addr 0x1003 data 0x000000AB -> one beat: addr 0x1000, be 4'b1000, wdata 0xAB000000; mem_write rises the cycle after the push.
//  2. SH addr 0x1002 data 0x00001234 -> addr 0x1000, be 4'b1100, wdata 0x12340000; single beat, count returns to 0.
//  3. SW addr 0x2003 data 0xDDCCBBAA -> beat1: addr 0x2000, be 4'b1000, wdata 0xAA000000. Beat2: addr 0x2004, be 4'b0111, wdata 0x00DDCCBB. Pop only after the 2nd mem_resp.
//  4. mem_resp held 0; push 5 stores back-to-back -> st_ready=0 after the 4th push, count=4, 5th not accepted. Then release mem_resp -> 4 writes in push order with no bubble between them.
//  5. rst pulsed during WR_HI of a split store -> next cycle mem_write=0, count=0, st_ready=1; no HI beat is ever issued.
//  6. count=2, push in the same cycle as the final mem_resp -> count stays 2; the next beat is the old 2nd entry.

Source files
------------

// File: rtl/store_align_pkg.sv
// ---------------------------------------------------------------------------
// store_align_pkg
// Shared types for the store-data path between the MEM stage and the
// data-memory port: access-size encoding, queue FSM states, the queue entry
// layout and a size-clamping helper.
// ---------------------------------------------------------------------------
package store_align_pkg;

  // Access size as log2(bytes).
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  // Write-port sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } sq_state_t;

  // Native widths of the core this path was written for.
  localparam int unsigned SQ_ADDR_W = 32;
  localparam int unsigned SQ_DATA_W = 32;

  // Queue entry layout at the native width. The queue declares an
  // identically ordered, width-parametrised copy so it can be reused on
  // wider data ports.
  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
    size_t                size;
  } sq_entry_t;

  // A store wider than the data port cannot be expressed as at most two
  // beats, so its size is clamped to a full port word.
  function automatic size_t clamp_size(input logic [1:0]  size,
                                       input int unsigned max_size);
    if ({30'd0, size} > max_size) begin
      return size_t'(max_size[1:0]);
    end
    return size_t'(size);
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// ---------------------------------------------------------------------------
// store_lane_align
// Purely combinational store aligner. Places right-justified store data and
// its byte enables onto the memory byte lanes selected by the address
// offset, and reports whether the access spills into the next word.
// Written so the load-side extractor can reuse the same lane arithmetic.
//
// Ports
//   addr_i      byte address of the access
//   data_i      right-justified store data
//   size_i      access size (log2 bytes), already clamped to the port width
//   lo_addr_o   word-aligned address of the first beat
//   hi_addr_o   address of the following word (second beat)
//   lo_be_o     byte enables of the first beat
//   hi_be_o     byte enables of the second beat
//   lo_wdata_o  lane-aligned data of the first beat (disabled bytes zero)
//   hi_wdata_o  lane-aligned data of the second beat (disabled bytes zero)
//   split_o     access crosses a word boundary and needs the second beat
// DATA_W is a power of two and at least 16.
// ---------------------------------------------------------------------------
module store_lane_align
  import store_align_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  input  size_t               size_i,
  output logic [ADDR_W-1:0]   lo_addr_o,
  output logic [ADDR_W-1:0]   hi_addr_o,
  output logic [DATA_W/8-1:0] lo_be_o,
  output logic [DATA_W/8-1:0] hi_be_o,
  output logic [DATA_W-1:0]   lo_wdata_o,
  output logic [DATA_W-1:0]   hi_wdata_o,
  output logic                split_o
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OB    = $clog2(BYTES);
  localparam int unsigned SW    = OB + 5;

  logic [OB-1:0]         off;
  logic [3:0]            nb;
  logic [2*BYTES-1:0]    mask;
  logic [2*DATA_W-1:0]   shifted;
  logic [2*DATA_W-1:0]   masked;
  logic [SW-1:0]         span;
  logic [ADDR_W-1:0]     base;

  assign off = addr_i[OB-1:0];
  assign nb  = 4'd1 << size_i;

  // Both the mask and the data are shifted in a double-width window so the
  // upper half directly becomes the second beat.
  assign mask    = (~({(2*BYTES){1'b1}} << nb)) << off;
  assign shifted = {{DATA_W{1'b0}}, data_i} << {off, 3'b000};

  // Caller data above the access size is not guaranteed to be zero, so
  // every lane without an enable is forced to zero.
  always_comb begin
    masked = '0;
    for (int i = 0; i < 2 * BYTES; i++) begin
      masked[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : 8'h00;
    end
  end

  assign span    = SW'(off) + SW'(nb);
  assign split_o = (span > SW'(BYTES));

  assign base       = {addr_i[ADDR_W-1:OB], {OB{1'b0}}};
  assign lo_addr_o  = base;
  assign hi_addr_o  = base + ADDR_W'(BYTES);
  assign lo_be_o    = mask[BYTES-1:0];
  assign hi_be_o    = mask[2*BYTES-1:BYTES];
  assign lo_wdata_o = masked[DATA_W-1:0];
  assign hi_wdata_o = masked[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/store_align_queue.sv
// ---------------------------------------------------------------------------
// store_align_queue
// Store-data path between the MEM stage and the data-memory port. Queues up
// to DEPTH stores, aligns each to its byte lanes and issues one memory write
// at a time, splitting word-crossing stores into a LO and a HI beat.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   st_valid         store request valid
//   st_ready         queue can accept a store (not full)
//   st_addr          byte address of the store
//   st_data          right-justified store data
//   st_size          log2(bytes); clamped to the port width on push
//   mem_write        write request, held until mem_resp
//   mem_address      word-aligned write address
//   mem_wdata        lane-aligned write data
//   mem_byte_enable  byte-lane enables
//   mem_resp         one-cycle write acknowledge
//   count            occupied queue entries
//   busy             entries pending or a write in progress
// ---------------------------------------------------------------------------
module store_align_queue
  import store_align_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [1:0]                 st_size,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_byte_enable,
  input  logic                       mem_resp,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OB    = $clog2(BYTES);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    size_t             size;
  } entry_t;

  entry_t              fifo_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  sq_state_t           state_q, state_d;
  logic                split_q;

  logic                full;
  logic                push;
  logic                pop;
  entry_t              head_nxt;

  logic [ADDR_W-1:0]   al_lo_addr, al_hi_addr;
  logic [BYTES-1:0]    al_lo_be, al_hi_be;
  logic [DATA_W-1:0]   al_lo_wdata, al_hi_wdata;
  logic                al_split;

  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BYTES-1:0]    mem_be_q, mem_be_d;

  assign full = (count_q == CW'(DEPTH));
  assign push = st_valid & ~full;

  // Next-state logic. A store is popped only once its last beat is
  // acknowledged; with more work queued the FSM stays in WR_LO so the next
  // head is presented on the very next cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        if (mem_resp) begin
          if (split_q) begin
            state_d = WR_HI;
          end else begin
            pop     = 1'b1;
            state_d = (count_q > CW'(1)) ? WR_LO : IDLE;
          end
        end
      end
      WR_HI: begin
        if (mem_resp) begin
          pop     = 1'b1;
          state_d = (count_q > CW'(1)) ? WR_LO : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  // The output registers are loaded from the entry that will be at the head
  // after this edge, so the beat appears together with the state change.
  // Any entry read here was written on an earlier edge: the FSM leaves IDLE
  // only when the queue already holds data, and the next head after a pop
  // exists only when more than one entry was queued.
  assign head_nxt = fifo_q[rd_ptr_d];

  store_lane_align #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_align (
    .addr_i     (head_nxt.addr),
    .data_i     (head_nxt.data),
    .size_i     (head_nxt.size),
    .lo_addr_o  (al_lo_addr),
    .hi_addr_o  (al_hi_addr),
    .lo_be_o    (al_lo_be),
    .hi_be_o    (al_hi_be),
    .lo_wdata_o (al_lo_wdata),
    .hi_wdata_o (al_hi_wdata),
    .split_o    (al_split)
  );

  // Beat selection off the next state; everything reads as zero in IDLE.
  always_comb begin
    mem_write_d   = 1'b0;
    mem_address_d = '0;
    mem_wdata_d   = '0;
    mem_be_d      = '0;
    unique case (state_d)
      WR_LO: begin
        mem_write_d   = 1'b1;
        mem_address_d = al_lo_addr;
        mem_wdata_d   = al_lo_wdata;
        mem_be_d      = al_lo_be;
      end
      WR_HI: begin
        mem_write_d   = 1'b1;
        mem_address_d = al_hi_addr;
        mem_wdata_d   = al_hi_wdata;
        mem_be_d      = al_hi_be;
      end
      default: begin
        mem_write_d = 1'b0;
      end
    endcase
  end

  // Control state and output registers. Reset wins at the next edge even in
  // the middle of a split store, so a pending HI beat is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      split_q       <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      split_q       <= al_split;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
    end
  end

  // Entry storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{addr: st_addr,
                            data: st_data,
                            size: clamp_size(st_size, OB)};
    end
  end

  assign st_ready        = ~full;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign count           = count_q;
  assign busy            = (count_q != '0) || (state_q != IDLE);

endmodule
